// File: rtl/mmc1_pkg.sv
// Shared MMC1 definitions: register indices, serial protocol width and the
// bit-counter decode used by the serial loader and the downstream register bank.
package mmc1_pkg;

    localparam logic [1:0] REG_CONTROL        = 2'd0;
    localparam logic [1:0] REG_CHR0           = 2'd1;
    localparam logic [1:0] REG_CHR1           = 2'd2;
    localparam logic [1:0] REG_PRG            = 2'd3;

    localparam int         SERIAL_BITS        = 5;
    localparam logic [1:0] CONTROL_RESET_MODE = 2'b11;

    // Count value at which the next accepted bit completes a register value.
    localparam logic [2:0] LAST_BIT_IDX       = 3'(SERIAL_BITS - 1);

    typedef logic [2:0] bit_count_t;

    typedef struct packed {
        logic       we;
        logic [1:0] sel;
        logic [4:0] data;
    } commit_t;

    // Counts 5-7 cannot be reached; they are folded back to IDLE.
    function automatic bit_count_t count_decode(input bit_count_t cnt);
        bit_count_t res;
        if (cnt <= LAST_BIT_IDX) begin
            res = cnt;
        end else begin
            res = 3'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mmc1_write_detect.sv
// CPU bus write qualifier for $8000-$FFFF: flags ROM writes and, optionally,
// discards a write that directly follows another one (MMC1B read-modify-write).
module mmc1_write_detect #(
    parameter bit IGNORE_CONSECUTIVE = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic romsel_n_i,
    input  logic cpu_rw_i,
    output logic accept_o
);

    logic wr_hit_s;
    logic prev_hit_q;
    logic prev_hit_d;

    // Qualify the write and decide whether it is accepted this cycle.
    always_comb begin
        wr_hit_s   = 1'b0;
        prev_hit_d = 1'b0;
        accept_o   = 1'b0;
        wr_hit_s   = (~romsel_n_i) & (~cpu_rw_i);
        prev_hit_d = wr_hit_s;
        if (IGNORE_CONSECUTIVE) begin
            accept_o = wr_hit_s & (~prev_hit_q);
        end else begin
            accept_o = wr_hit_s;
        end
    end

    // Remember every hit, accepted or not, so a run of writes yields one accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_hit_q <= 1'b0;
        end else begin
            prev_hit_q <= prev_hit_d;
        end
    end

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial-port front end: shifts one bit per accepted ROM write and emits a
// registered one-cycle commit (index + 5-bit value) or serial-reset pulse.
module mmc1_serial_loader
    import mmc1_pkg::*;
#(
    parameter bit IGNORE_CONSECUTIVE = 1'b1,
    parameter bit RESET_ON_BIT7      = 1'b1
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       romsel,
    input  logic       cpu_rw_in,
    input  logic [1:0] cpu_addr_in,
    input  logic [7:0] cpu_data_in,
    output logic       reg_we,
    output logic [1:0] reg_sel,
    output logic [4:0] reg_data,
    output logic       serial_reset,
    output logic [2:0] bit_count
);

    logic       accept_s;
    logic       unused_data_s;
    bit_count_t count_cur_s;
    logic [4:0] shift_next_s;

    logic [4:0] shift_q,        shift_d;
    bit_count_t bit_count_q,    bit_count_d;
    commit_t    commit_q,       commit_d;
    logic       serial_reset_q, serial_reset_d;

    assign unused_data_s = ^cpu_data_in[6:1];

    mmc1_write_detect #(
        .IGNORE_CONSECUTIVE (IGNORE_CONSECUTIVE)
    ) u_write_detect (
        .clk_i      (m2),
        .reset_i    (reset),
        .romsel_n_i (romsel),
        .cpu_rw_i   (cpu_rw_in),
        .accept_o   (accept_s)
    );

    // Shift/count next state; commit index and data come from the fifth write only.
    always_comb begin
        count_cur_s    = count_decode(bit_count_q);
        shift_next_s   = {cpu_data_in[0], shift_q[4:1]};
        shift_d        = shift_q;
        bit_count_d    = count_cur_s;
        commit_d       = commit_q;
        commit_d.we    = 1'b0;
        serial_reset_d = 1'b0;
        if (accept_s) begin
            if (RESET_ON_BIT7 && cpu_data_in[7]) begin
                shift_d        = 5'd0;
                bit_count_d    = 3'd0;
                serial_reset_d = 1'b1;
            end else if (count_cur_s == LAST_BIT_IDX) begin
                commit_d.we    = 1'b1;
                commit_d.sel   = cpu_addr_in;
                commit_d.data  = shift_next_s;
                shift_d        = 5'd0;
                bit_count_d    = 3'd0;
            end else begin
                shift_d        = shift_next_s;
                bit_count_d    = count_cur_s + 3'd1;
            end
        end else begin
            shift_d     = shift_q;
            bit_count_d = count_cur_s;
        end
    end

    // State and output registers; reset wins over a simultaneous write.
    always_ff @(posedge m2) begin
        if (reset) begin
            shift_q        <= 5'd0;
            bit_count_q    <= 3'd0;
            commit_q       <= '0;
            serial_reset_q <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_count_q    <= bit_count_d;
            commit_q       <= commit_d;
            serial_reset_q <= serial_reset_d;
        end
    end

    assign reg_we       = commit_q.we;
    assign reg_sel      = commit_q.sel;
    assign reg_data     = commit_q.data;
    assign serial_reset = serial_reset_q;
    assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Directed self-checking bench for mmc1_serial_loader; a second instance with
// both options disabled covers the non-suppressing / bit-7-as-data behaviour.
module tb_mmc1_serial_loader;

    logic       m2 = 1'b0;
    logic       reset;
    logic       romsel;
    logic       cpu_rw_in;
    logic [1:0] cpu_addr_in;
    logic [7:0] cpu_data_in;

    logic       reg_we, serial_reset;
    logic [1:0] reg_sel;
    logic [4:0] reg_data;
    logic [2:0] bit_count;

    logic       u2_reg_we, u2_serial_reset;
    logic [1:0] u2_reg_sel;
    logic [4:0] u2_reg_data;
    logic [2:0] u2_bit_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 m2 = ~m2;

    mmc1_serial_loader #(.IGNORE_CONSECUTIVE(1'b1), .RESET_ON_BIT7(1'b1)) dut (
        .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .reg_we(reg_we), .reg_sel(reg_sel), .reg_data(reg_data),
        .serial_reset(serial_reset), .bit_count(bit_count)
    );

    mmc1_serial_loader #(.IGNORE_CONSECUTIVE(1'b0), .RESET_ON_BIT7(1'b0)) dut2 (
        .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
        .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .reg_we(u2_reg_we), .reg_sel(u2_reg_sel), .reg_data(u2_reg_data),
        .serial_reset(u2_serial_reset), .bit_count(u2_bit_count)
    );

    task automatic drive(input logic rs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        @(negedge m2);
        romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d;
    endtask

    // Write cycle followed by an idle cycle; returns just after the write's edge.
    task automatic write_byte(input logic [1:0] a, input logic [7:0] d);
        drive(1'b0, 1'b0, a, d);
        drive(1'b1, 1'b1, 2'd0, 8'h00);
    endtask

    task automatic write_bit(input logic [1:0] a, input logic b);
        write_byte(a, {7'd0, b});
    endtask

    task automatic apply_reset();
        @(negedge m2);
        reset = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1; cpu_addr_in = 2'd0; cpu_data_in = 8'h00;
        @(negedge m2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (reg_we !== 1'b0)       begin n_err++; $display("FAIL rst_reg_we got %0h want 0", reg_we); end
        n_cmp++; if (serial_reset !== 1'b0) begin n_err++; $display("FAIL rst_serial_reset got %0h want 0", serial_reset); end
        n_cmp++; if (reg_sel !== 2'd0)      begin n_err++; $display("FAIL rst_reg_sel got %0h want 0", reg_sel); end
        n_cmp++; if (reg_data !== 5'd0)     begin n_err++; $display("FAIL rst_reg_data got %0h want 0", reg_data); end
        n_cmp++; if (bit_count !== 3'd0)    begin n_err++; $display("FAIL rst_bit_count got %0h want 0", bit_count); end
        n_cmp++; if (u2_bit_count !== 3'd0) begin n_err++; $display("FAIL rst_u2_bit_count got %0h want 0", u2_bit_count); end
    endtask

    task automatic test_basic_commit();
        logic seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            write_bit(2'd3, seq[i]);
            if (i < 4) begin
                n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL basic_early_we[%0d] got %0h want 0", i, reg_we); end
                n_cmp++; if (bit_count !== 3'(i + 1)) begin n_err++; $display("FAIL basic_count[%0d] got %0d want %0d", i, bit_count, i + 1); end
            end else begin
                n_cmp++; if (reg_we !== 1'b1)      begin n_err++; $display("FAIL basic_we got %0h want 1", reg_we); end
                n_cmp++; if (reg_sel !== 2'd3)     begin n_err++; $display("FAIL basic_sel got %0h want 3", reg_sel); end
                n_cmp++; if (reg_data !== 5'b01101) begin n_err++; $display("FAIL basic_data got %b want 01101", reg_data); end
                n_cmp++; if (bit_count !== 3'd0)   begin n_err++; $display("FAIL basic_count_end got %0d want 0", bit_count); end
            end
        end
        @(negedge m2);
        n_cmp++; if (reg_we !== 1'b0)       begin n_err++; $display("FAIL basic_we_one_cycle got %0h want 0", reg_we); end
        n_cmp++; if (reg_data !== 5'b01101) begin n_err++; $display("FAIL basic_data_hold got %b want 01101", reg_data); end
    endtask

    task automatic test_addr_select();
        logic [1:0] addrs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        for (int i = 0; i < 5; i++) begin
            write_bit(addrs[i], 1'b1);
        end
        n_cmp++; if (reg_we !== 1'b1)       begin n_err++; $display("FAIL addr_we got %0h want 1", reg_we); end
        n_cmp++; if (reg_sel !== 2'd1)      begin n_err++; $display("FAIL addr_sel got %0h want 1", reg_sel); end
        n_cmp++; if (reg_data !== 5'b11111) begin n_err++; $display("FAIL addr_data got %b want 11111", reg_data); end
    endtask

    task automatic test_serial_reset();
        logic seq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        write_bit(2'd0, 1'b1);
        write_bit(2'd0, 1'b1);
        write_bit(2'd0, 1'b0);
        write_byte(2'd2, 8'h80);
        n_cmp++; if (serial_reset !== 1'b1) begin n_err++; $display("FAIL sr_pulse got %0h want 1", serial_reset); end
        n_cmp++; if (reg_we !== 1'b0)       begin n_err++; $display("FAIL sr_no_we got %0h want 0", reg_we); end
        n_cmp++; if (bit_count !== 3'd0)    begin n_err++; $display("FAIL sr_count got %0d want 0", bit_count); end
        n_cmp++; if (reg_data !== 5'b11111) begin n_err++; $display("FAIL sr_data_hold got %b want 11111", reg_data); end
        n_cmp++; if (u2_bit_count !== 3'd4) begin n_err++; $display("FAIL sr_u2_bit7_as_data got %0d want 4", u2_bit_count); end
        @(negedge m2);
        n_cmp++; if (serial_reset !== 1'b0) begin n_err++; $display("FAIL sr_one_cycle got %0h want 0", serial_reset); end
        for (int i = 0; i < 5; i++) begin
            write_bit(2'd0, seq[i]);
        end
        n_cmp++; if (reg_we !== 1'b1)       begin n_err++; $display("FAIL sr_after_we got %0h want 1", reg_we); end
        n_cmp++; if (reg_sel !== 2'd0)      begin n_err++; $display("FAIL sr_after_sel got %0h want 0", reg_sel); end
        n_cmp++; if (reg_data !== 5'b10010) begin n_err++; $display("FAIL sr_after_data got %b want 10010", reg_data); end
    endtask

    task automatic test_reset_mid();
        logic seq [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        write_bit(2'd3, 1'b1);
        write_bit(2'd3, 1'b0);
        write_bit(2'd3, 1'b1);
        write_bit(2'd3, 1'b0);
        n_cmp++; if (bit_count !== 3'd4) begin n_err++; $display("FAIL rm_loaded got %0d want 4", bit_count); end
        @(negedge m2);
        reset = 1'b1; romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 2'd2; cpu_data_in = 8'h01;
        @(negedge m2);
        reset = 1'b0; romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 2'd0; cpu_data_in = 8'h01;
        n_cmp++; if (bit_count !== 3'd0) begin n_err++; $display("FAIL rm_count got %0d want 0", bit_count); end
        n_cmp++; if (reg_we !== 1'b0)    begin n_err++; $display("FAIL rm_we got %0h want 0", reg_we); end
        n_cmp++; if (reg_sel !== 2'd0)   begin n_err++; $display("FAIL rm_sel got %0h want 0", reg_sel); end
        n_cmp++; if (reg_data !== 5'd0)  begin n_err++; $display("FAIL rm_data got %b want 00000", reg_data); end
        drive(1'b1, 1'b1, 2'd0, 8'h00);
        n_cmp++; if (bit_count !== 3'd1) begin n_err++; $display("FAIL rm_first_write got %0d want 1", bit_count); end
        for (int i = 0; i < 4; i++) begin
            write_bit(2'd2, seq[i]);
        end
        n_cmp++; if (reg_we !== 1'b1)       begin n_err++; $display("FAIL rm_commit_we got %0h want 1", reg_we); end
        n_cmp++; if (reg_sel !== 2'd2)      begin n_err++; $display("FAIL rm_commit_sel got %0h want 2", reg_sel); end
        n_cmp++; if (reg_data !== 5'b11101) begin n_err++; $display("FAIL rm_commit_data got %b want 11101", reg_data); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1'b0, 1'b0, 2'd0, 8'h01);
        drive(1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 1'b1, 2'd0, 8'h00);
        n_cmp++; if (bit_count !== 3'd1)    begin n_err++; $display("FAIL b2b_count got %0d want 1", bit_count); end
        n_cmp++; if (u2_bit_count !== 3'd2) begin n_err++; $display("FAIL b2b_u2_count got %0d want 2", u2_bit_count); end
        drive(1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 1'b0, 2'd0, 8'h80);
        drive(1'b1, 1'b1, 2'd0, 8'h00);
        n_cmp++; if (serial_reset !== 1'b0) begin n_err++; $display("FAIL b2b_bit7_suppressed got %0h want 0", serial_reset); end
        n_cmp++; if (bit_count !== 3'd2)    begin n_err++; $display("FAIL b2b_count2 got %0d want 2", bit_count); end
        n_cmp++; if (u2_bit_count !== 3'd4) begin n_err++; $display("FAIL b2b_u2_count2 got %0d want 4", u2_bit_count); end
    endtask

    task automatic test_interleave();
        logic seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            write_bit(2'd1, seq[i]);
            if (i == 4) begin
                n_cmp++; if (reg_we !== 1'b1)       begin n_err++; $display("FAIL il_we got %0h want 1", reg_we); end
                n_cmp++; if (reg_sel !== 2'd1)      begin n_err++; $display("FAIL il_sel got %0h want 1", reg_sel); end
                n_cmp++; if (reg_data !== 5'b10100) begin n_err++; $display("FAIL il_data got %b want 10100", reg_data); end
            end
            drive(1'b0, 1'b1, 2'd3, 8'h81);
            drive(1'b1, 1'b0, 2'd2, 8'h81);
            drive(1'b1, 1'b1, 2'd0, 8'h00);
            n_cmp++; if (bit_count !== ((i < 4) ? 3'(i + 1) : 3'd0)) begin n_err++; $display("FAIL il_count[%0d] got %0d", i, bit_count); end
            n_cmp++; if ((reg_we | serial_reset) !== 1'b0) begin n_err++; $display("FAIL il_quiet[%0d] got we=%0h sr=%0h want 0", i, reg_we, serial_reset); end
        end
    endtask

    initial begin
        reset = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1; cpu_addr_in = 2'd0; cpu_data_in = 8'h00;
        repeat (2) @(negedge m2);
        test_reset();
        test_basic_commit();
        test_addr_select();
        test_serial_reset();
        test_reset_mid();
        test_back_to_back();
        test_interleave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
